cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
Multi-layer job sequencer that sits between the AXI-lite CPU register bank and the CNN core (ctrl/buffers/dpi/calculate/dpo/cnn_dma) top. It holds up to NUM_LAYERS layer descriptors. On one CPU start it runs them back-to-back, for each layer:
- soft-resetting the core,
- presenting the descriptor,
- pulsing start,
- waiting for the core's over.
It adds abort, a per-layer timeout, a cycle counter and an interrupt, none of which the single-layer start/over glue provides.

Parameters:
NUM_LAYERS, 8, descriptor slots; power of two, >=2
LIDX_W, $clog2(NUM_LAYERS), layer index width
DW, 32, descriptor field width
RST_CYC, 2, core soft-reset low cycles between layers (>=1)
TMO_W, 24, timeout counter width
CNT_W, 32, total-cycle counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cpu_start  in  32  bit0 start (rising edge), bit1 abort (level)
cpu_layer_cnt  in  LIDX_W+1  layers to run; sampled at start
cpu_timeout  in  TMO_W  per-layer cycle limit; 0 = disabled
cfg_wr_en  in  1  descriptor write strobe
cfg_wr_layer  in  LIDX_W  slot index
cfg_wr_field  in  3  0 ins_a, 1 ins_b, 2 r_addr, 3 w_addr, 4 weight_addr, 5 data_limit, 6 weight_limit
cfg_wr_data  in  DW  field value
core_rstn  out  1  core soft reset, active-low
core_start  out  1  one-cycle start pulse to core ctrl
core_ins_a, core_ins_b, core_r_addr, core_w_addr, core_weight_addr, core_data_limit, core_weight_limit  out  DW each  registered current-layer descriptor
core_over  in  1  core layer-complete (level or pulse)
seq_busy  out  1  sequence in progress
seq_done  out  1  sticky; last sequence completed
seq_err  out  2  sticky; bit0 timeout, bit1 abort
cur_layer  out  LIDX_W  layer in flight / last run
cycle_cnt  out  CNT_W  cycles from start to DONE/ERR
irq  out  1  one-cycle pulse on DONE or error

Behaviour:
- Reset values:
  - core_rstn=0, then released through a 2-flop synchroniser after rstn deasserts.
  - All other outputs 0; descriptor regs 0.
- Start edge detection: registered cpu_start[0]; edge = cur & ~prev. Edges while seq_busy are ignored.
- Descriptor writes:
  - Fields 7 are ignored.
  - Writes while seq_busy are dropped; stored descriptors never change mid-run.
- Layer count: cpu_layer_cnt=0 is treated as 1; values >NUM_LAYERS are clamped to NUM_LAYERS. The count is latched on the start edge.
- FSM states: IDLE, LOAD, CRST, START, RUN, NEXT, DONE, ABORT.
  - IDLE: on start edge, clear seq_done, seq_err and cycle_cnt; set cur_layer=0; go to LOAD.
  - LOAD: copy slot cur_layer to core_* outputs; go to CRST.
  - CRST: core_rstn=0 for exactly RST_CYC cycles; go to START.
  - START: core_rstn=1, core_start=1 for one cycle; clear the timeout counter; go to RUN.
  - RUN, evaluated in this order:
    1. core_over=1: go to DONE if cur_layer==count-1, else NEXT.
    2. Abort (bit1): set seq_err[1]; go to ABORT.
    3. Timeout counter reaches cpu_timeout (nonzero): set seq_err[0]; go to ABORT.
  - Precedence: core_over beats abort and timeout when they coincide. Abort beats timeout.
  - NEXT: cur_layer+1; go to LOAD.
  - DONE: seq_done=1, irq=1 for one cycle; go to IDLE. core_rstn stays 1.
  - ABORT: core_rstn=0 for RST_CYC cycles, irq=1 in the first cycle; go to IDLE. cur_layer holds the failing layer.
- Abort is also honoured in LOAD, CRST and START, same handling as RUN.
- Latency:
  - Start edge sampled at cycle t gives core_start at t+3+RST_CYC.
  - core_over at cycle u on a non-final layer gives the next core_start at u+3+RST_CYC.
- Counters:
  - seq_busy=1 in every state except IDLE.
  - cycle_cnt increments every busy cycle and saturates at all-ones.
  - The timeout counter saturates and counts only in RUN.
- Asynchronous rstn mid-run: everything returns to reset values immediately, including descriptors.

Decomposition:
- Shared package/header: field-select codes, FSM state encodings, seq_err bit positions.
- One natural sub-module: cnn_desc_regfile. It holds NUM_LAYERS×7×DW storage with a write port and a registered read of a whole slot.

Test Plan:
- Run 3 layers, RST_CYC=2, core_over returned 10 cycles after each core_start. Required:
  - core_start at t+5;
  - core_* shows slots 0, 1, 2 in turn;
  - seq_done=1, one irq;
  - cycle_cnt=44.
- cpu_layer_cnt=0, then cpu_layer_cnt=15 with NUM_LAYERS=8 -> runs 1 layer, then 8 layers.
- cpu_timeout=20 with core_over never returned -> seq_err=01, irq pulse, core_rstn low 2 cycles, cur_layer=0, seq_busy=0.
- Abort asserted in RUN of layer 1 in the same cycle as core_over -> layer 1 completes and layer 2 starts. Abort held one more cycle -> seq_err=10, cur_layer=2.
- Second start edge plus a cfg write to slot 0 during RUN -> both ignored; slot 0 readback unchanged on the next run.
- rstn pulsed low mid-RUN -> all outputs 0 asynchronously; after release core_rstn returns to 1 on the 2nd clk.

Source files
------------

// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared constants for the multi-layer CNN job sequencer: descriptor field codes,
// FSM state encodings and sticky error bit positions.
package cnn_layer_sequencer_pkg;

  localparam int unsigned NumFields = 7;

  localparam logic [2:0] FldInsA        = 3'd0;
  localparam logic [2:0] FldInsB        = 3'd1;
  localparam logic [2:0] FldRAddr       = 3'd2;
  localparam logic [2:0] FldWAddr       = 3'd3;
  localparam logic [2:0] FldWeightAddr  = 3'd4;
  localparam logic [2:0] FldDataLimit   = 3'd5;
  localparam logic [2:0] FldWeightLimit = 3'd6;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StCrst  = 3'd2;
  localparam logic [2:0] StStart = 3'd3;
  localparam logic [2:0] StRun   = 3'd4;
  localparam logic [2:0] StNext  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StAbort = 3'd7;

  localparam int unsigned ErrTmo   = 0;
  localparam int unsigned ErrAbort = 1;

endpackage

// File: rtl/cnn_desc_regfile.sv
// Layer descriptor storage: NUM_LAYERS slots of seven DW-bit fields, one write port
// and a registered whole-slot read.
module cnn_desc_regfile
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned LIDX_W     = $clog2(NUM_LAYERS),
  parameter int unsigned DW         = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_en,
  input  logic [LIDX_W-1:0]             wr_layer,
  input  logic [2:0]                    wr_field,
  input  logic [DW-1:0]                 wr_data,
  input  logic                          rd_en,
  input  logic [LIDX_W-1:0]             rd_layer,
  output logic [NumFields-1:0][DW-1:0]  rd_data
);

  logic [NumFields-1:0][DW-1:0] mem_q [NUM_LAYERS];

  // Field code 7 has no storage behind it and is silently dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LAYERS; i++) mem_q[i] <= '0;
    end else if (wr_en && (wr_field != 3'd7)) begin
      mem_q[wr_layer][wr_field] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_q[rd_layer];
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs up to NUM_LAYERS stored layer descriptors back-to-back on the CNN core, with
// per-layer soft reset, abort, timeout, total-cycle counter and completion interrupt.
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned LIDX_W     = $clog2(NUM_LAYERS),
  parameter int unsigned DW         = 32,
  parameter int unsigned RST_CYC    = 2,
  parameter int unsigned TMO_W      = 24,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       cpu_start,
  input  logic [LIDX_W:0]   cpu_layer_cnt,
  input  logic [TMO_W-1:0]  cpu_timeout,
  input  logic              cfg_wr_en,
  input  logic [LIDX_W-1:0] cfg_wr_layer,
  input  logic [2:0]        cfg_wr_field,
  input  logic [DW-1:0]     cfg_wr_data,
  output logic              core_rstn,
  output logic              core_start,
  output logic [DW-1:0]     core_ins_a,
  output logic [DW-1:0]     core_ins_b,
  output logic [DW-1:0]     core_r_addr,
  output logic [DW-1:0]     core_w_addr,
  output logic [DW-1:0]     core_weight_addr,
  output logic [DW-1:0]     core_data_limit,
  output logic [DW-1:0]     core_weight_limit,
  input  logic              core_over,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [1:0]        seq_err,
  output logic [LIDX_W-1:0] cur_layer,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              irq
);

  localparam int unsigned    RcW    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RcW-1:0] RcLast = RcW'(RST_CYC - 1);
  localparam logic [LIDX_W:0] MaxCnt = (LIDX_W + 1)'(NUM_LAYERS);

  logic [2:0]              state_q, state_d;
  logic                    start_q, start_prev_q, abort_q;
  logic [1:0]              rst_sync_q;
  logic [LIDX_W-1:0]       cur_layer_q, cur_layer_d;
  logic [LIDX_W:0]         cnt_q, cnt_d;
  logic [RcW-1:0]          rcnt_q, rcnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d;
  logic                    seq_done_q, seq_done_d;
  logic [1:0]              seq_err_q, seq_err_d;
  logic                    start_edge, last_layer, go_abort, go_tmo;
  logic [NumFields-1:0][DW-1:0] desc_q;
  logic                    unused_start;

  assign unused_start = ^cpu_start[31:2];

  function automatic logic [LIDX_W:0] clamp_cnt(input logic [LIDX_W:0] c);
    if (c == '0) return (LIDX_W + 1)'(1);
    if (c > MaxCnt) return MaxCnt;
    return c;
  endfunction

  assign start_edge = start_q & ~start_prev_q;
  assign last_layer = ({1'b0, cur_layer_q} == (cnt_q - (LIDX_W + 1)'(1)));

  always_comb begin
    state_d     = state_q;
    cur_layer_d = cur_layer_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    seq_done_d  = seq_done_q;
    seq_err_d   = seq_err_q;
    go_abort    = 1'b0;
    go_tmo      = 1'b0;

    // DONE/ABORT are not counted: the value reports cycles up to the terminal state.
    if ((state_q inside {StLoad, StCrst, StStart, StRun, StNext}) && (cyc_q != '1)) begin
      cyc_d = cyc_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          seq_done_d  = 1'b0;
          seq_err_d   = '0;
          cyc_d       = '0;
          cur_layer_d = '0;
          cnt_d       = clamp_cnt(cpu_layer_cnt);
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (abort_q) begin
          go_abort = 1'b1;
        end else begin
          rcnt_d  = '0;
          state_d = StCrst;
        end
      end
      StCrst: begin
        if (abort_q) begin
          go_abort = 1'b1;
        end else if (rcnt_q == RcLast) begin
          state_d = StStart;
        end else begin
          rcnt_d = rcnt_q + RcW'(1);
        end
      end
      StStart: begin
        if (abort_q) begin
          go_abort = 1'b1;
        end else begin
          tmo_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (core_over) begin
          if (last_layer) begin
            seq_done_d = 1'b1;
            state_d    = StDone;
          end else begin
            state_d = StNext;
          end
        end else if (abort_q) begin
          go_abort = 1'b1;
        end else if ((cpu_timeout != '0) && (tmo_q == cpu_timeout)) begin
          go_tmo = 1'b1;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StNext: begin
        cur_layer_d = cur_layer_q + LIDX_W'(1);
        state_d     = StLoad;
      end
      StDone: begin
        state_d = StIdle;
      end
      StAbort: begin
        if (rcnt_q == RcLast) begin
          state_d = StIdle;
        end else begin
          rcnt_d = rcnt_q + RcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_abort) seq_err_d[ErrAbort] = 1'b1;
    if (go_tmo)   seq_err_d[ErrTmo]   = 1'b1;
    if (go_abort || go_tmo) begin
      rcnt_d  = '0;
      state_d = StAbort;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      abort_q      <= 1'b0;
      rst_sync_q   <= '0;
      cur_layer_q  <= '0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      tmo_q        <= '0;
      cyc_q        <= '0;
      seq_done_q   <= 1'b0;
      seq_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= cpu_start[0];
      start_prev_q <= start_q;
      abort_q      <= cpu_start[1];
      rst_sync_q   <= {rst_sync_q[0], 1'b1};
      cur_layer_q  <= cur_layer_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      tmo_q        <= tmo_d;
      cyc_q        <= cyc_d;
      seq_done_q   <= seq_done_d;
      seq_err_q    <= seq_err_d;
    end
  end

  cnn_desc_regfile #(
    .NUM_LAYERS (NUM_LAYERS),
    .LIDX_W     (LIDX_W),
    .DW         (DW)
  ) u_desc_regfile (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (cfg_wr_en && (state_q == StIdle)),
    .wr_layer (cfg_wr_layer),
    .wr_field (cfg_wr_field),
    .wr_data  (cfg_wr_data),
    .rd_en    (state_q == StLoad),
    .rd_layer (cur_layer_q),
    .rd_data  (desc_q)
  );

  assign core_ins_a        = desc_q[FldInsA];
  assign core_ins_b        = desc_q[FldInsB];
  assign core_r_addr       = desc_q[FldRAddr];
  assign core_w_addr       = desc_q[FldWAddr];
  assign core_weight_addr  = desc_q[FldWeightAddr];
  assign core_data_limit   = desc_q[FldDataLimit];
  assign core_weight_limit = desc_q[FldWeightLimit];

  assign core_rstn  = rst_sync_q[1] & ~((state_q == StCrst) || (state_q == StAbort));
  assign core_start = (state_q == StStart);
  assign irq        = (state_q == StDone) || ((state_q == StAbort) && (rcnt_q == '0));
  assign seq_busy   = (state_q != StIdle);
  assign seq_done   = seq_done_q;
  assign seq_err    = seq_err_q;
  assign cur_layer  = cur_layer_q;
  assign cycle_cnt  = cyc_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed self-checking bench for cnn_layer_sequencer with a simple core responder
// that returns core_over a fixed number of cycles after each core_start.
module tb_cnn_layer_sequencer;

  localparam int NL = 8;
  localparam int LW = 3;
  localparam int DW = 32;
  localparam int TW = 24;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   cpu_start = '0;
  logic [LW:0]   cpu_layer_cnt = '0;
  logic [TW-1:0] cpu_timeout = '0;
  logic          cfg_wr_en = 1'b0;
  logic [LW-1:0] cfg_wr_layer = '0;
  logic [2:0]    cfg_wr_field = '0;
  logic [DW-1:0] cfg_wr_data = '0;
  logic          core_over = 1'b0;
  logic          core_rstn, core_start, seq_busy, seq_done, irq;
  logic [DW-1:0] core_ins_a, core_ins_b, core_r_addr, core_w_addr;
  logic [DW-1:0] core_weight_addr, core_data_limit, core_weight_limit;
  logic [1:0]    seq_err;
  logic [LW-1:0] cur_layer;
  logic [CW-1:0] cycle_cnt;

  cnn_layer_sequencer #(
    .NUM_LAYERS (NL), .LIDX_W (LW), .DW (DW), .RST_CYC (2), .TMO_W (TW), .CNT_W (CW)
  ) dut (
    .clk (clk), .rstn (rstn), .cpu_start (cpu_start), .cpu_layer_cnt (cpu_layer_cnt),
    .cpu_timeout (cpu_timeout), .cfg_wr_en (cfg_wr_en), .cfg_wr_layer (cfg_wr_layer),
    .cfg_wr_field (cfg_wr_field), .cfg_wr_data (cfg_wr_data), .core_rstn (core_rstn),
    .core_start (core_start), .core_ins_a (core_ins_a), .core_ins_b (core_ins_b),
    .core_r_addr (core_r_addr), .core_w_addr (core_w_addr),
    .core_weight_addr (core_weight_addr), .core_data_limit (core_data_limit),
    .core_weight_limit (core_weight_limit), .core_over (core_over), .seq_busy (seq_busy),
    .seq_done (seq_done), .seq_err (seq_err), .cur_layer (cur_layer),
    .cycle_cnt (cycle_cnt), .irq (irq)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   over_at = -1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   irq_cnt = 0;
  bit   resp_en = 1'b1;
  int   starts[$];
  logic [31:0] insa_log[$];
  logic [31:0] wlim_log[$];

  function automatic logic [31:0] dval(input int l, input int f);
    return 32'hC0DE_0000 | 32'(l << 4) | 32'(f);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: outputs sampled 1ns after the edge; inputs set afterwards apply to this cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (core_start) begin
      starts.push_back(cyc);
      insa_log.push_back(core_ins_a);
      wlim_log.push_back(core_weight_limit);
      over_at = cyc + 10;
    end
    core_over = resp_en && (cyc == over_at);
    if (irq) irq_cnt++;
  endtask

  task automatic wr(input int l, input int f, input logic [31:0] d);
    cfg_wr_en = 1'b1;
    cfg_wr_layer = LW'(l);
    cfg_wr_field = 3'(f);
    cfg_wr_data = d;
    cycle();
    cfg_wr_en = 1'b0;
  endtask

  task automatic run_seq(input int cnt, output int t);
    starts.delete();
    insa_log.delete();
    wlim_log.delete();
    cpu_layer_cnt = (LW + 1)'(cnt);
    cpu_start[0] = 1'b1;
    t = cyc;
    cycle();
    cpu_start[0] = 1'b0;
  endtask

  task automatic wait_irq(input int budget, input string tag, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (irq) begin
        d = cyc;
        return;
      end
    end
    check({tag, "_irq_wait"}, 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, d, irq0, low, armed, hold;

    // Reset state
    cycle();
    cycle();
    check("rst_core_rstn", core_rstn, 0);
    check("rst_busy", seq_busy, 0);
    check("rst_done", seq_done, 0);
    check("rst_err", seq_err, 0);
    check("rst_cyc_cnt", cycle_cnt, 0);
    check("rst_cur_layer", cur_layer, 0);
    check("rst_core_start", core_start, 0);
    check("rst_irq", irq, 0);
    check("rst_ins_a", core_ins_a, 0);
    rstn = 1'b1;
    cycle();
    check("rel_core_rstn_clk1", core_rstn, 0);
    cycle();
    check("rel_core_rstn_clk2", core_rstn, 1);

    for (int l = 0; l < NL; l++)
      for (int f = 0; f < 7; f++) wr(l, f, dval(l, f));
    wr(3, 7, 32'hFFFF_FFFF);

    // Three-layer run
    irq0 = irq_cnt;
    run_seq(3, t);
    wait_irq(200, "run3", d);
    check("run3_nstarts", starts.size(), 3);
    check("run3_start_lat", starts[0] - t, 5);
    check("run3_gap1", starts[1] - starts[0], 15);
    check("run3_gap2", starts[2] - starts[1], 15);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("run3_ins_a%0d", i), insa_log[i], dval(i, 0));
      check($sformatf("run3_wlim%0d", i), wlim_log[i], dval(i, 6));
    end
    check("run3_irq_time", d - t, 46);
    check("run3_done", seq_done, 1);
    check("run3_cyc_cnt", cycle_cnt, 44);
    check("run3_err", seq_err, 0);
    check("run3_cur_layer", cur_layer, 2);
    check("run3_core_rstn", core_rstn, 1);
    cycle();
    check("run3_idle_busy", seq_busy, 0);
    repeat (3) cycle();
    check("run3_irq_count", irq_cnt - irq0, 1);

    // Layer count 0 -> 1 layer, 15 -> clamped to 8
    run_seq(0, t);
    wait_irq(200, "cnt0", d);
    check("cnt0_nstarts", starts.size(), 1);
    check("cnt0_cur_layer", cur_layer, 0);
    repeat (3) cycle();
    run_seq(15, t);
    wait_irq(400, "cnt15", d);
    check("cnt15_nstarts", starts.size(), 8);
    check("cnt15_cur_layer", cur_layer, 7);
    check("cnt15_ins_a7", insa_log[7], dval(7, 0));
    check("slot3_wlim_after_f7", wlim_log[3], dval(3, 6));
    check("slot3_ins_a_after_f7", insa_log[3], dval(3, 0));
    repeat (3) cycle();

    // Timeout with no core_over
    resp_en = 1'b0;
    cpu_timeout = TW'(20);
    run_seq(1, t);
    wait_irq(200, "tmo", d);
    check("tmo_irq_time", d - t, 27);
    check("tmo_err", seq_err, 2'b01);
    check("tmo_cur_layer", cur_layer, 0);
    check("tmo_done", seq_done, 0);
    low = core_rstn ? 0 : 1;
    for (int i = 0; i < 10 && !core_rstn; i++) begin
      cycle();
      if (!core_rstn) low++;
    end
    check("tmo_rstn_low", low, 2);
    check("tmo_busy", seq_busy, 0);
    cpu_timeout = '0;
    resp_en = 1'b1;
    repeat (3) cycle();

    // Abort coinciding with layer 1 core_over, held one more cycle
    run_seq(3, t);
    armed = 0;
    hold = 0;
    d = -1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (irq) begin
        d = cyc;
        break;
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) cpu_start[1] = 1'b0;
      end
      if (core_over && starts.size() == 2 && armed == 0) begin
        cpu_start[1] = 1'b1;
        hold = 2;
        armed = 1;
      end
    end
    cpu_start[1] = 1'b0;
    check("abort_irq_seen", d != -1, 1);
    check("abort_err", seq_err, 2'b10);
    check("abort_cur_layer", cur_layer, 2);
    check("abort_nstarts", starts.size(), 2);
    check("abort_done", seq_done, 0);
    repeat (4) cycle();

    // Restart and descriptor write while busy are both ignored
    run_seq(1, t);
    for (int i = 0; i < 20 && starts.size() == 0; i++) cycle();
    cycle();
    cfg_wr_en = 1'b1;
    cfg_wr_layer = '0;
    cfg_wr_field = 3'd0;
    cfg_wr_data = 32'hDEAD_BEEF;
    cpu_start[0] = 1'b1;
    cycle();
    cfg_wr_en = 1'b0;
    cpu_start[0] = 1'b0;
    wait_irq(100, "busy_ign", d);
    repeat (20) cycle();
    check("busy_restart_ignored", starts.size(), 1);
    run_seq(1, t);
    wait_irq(100, "busy_rerun", d);
    check("busy_wr_dropped", insa_log[0], dval(0, 0));
    repeat (3) cycle();

    // Asynchronous reset mid-run
    run_seq(2, t);
    for (int i = 0; i < 20 && starts.size() == 0; i++) cycle();
    repeat (3) cycle();
    rstn = 1'b0;
    #1;
    over_at = -1;
    core_over = 1'b0;
    check("arst_core_rstn", core_rstn, 0);
    check("arst_busy", seq_busy, 0);
    check("arst_ins_a", core_ins_a, 0);
    check("arst_w_addr", core_w_addr, 0);
    check("arst_cyc_cnt", cycle_cnt, 0);
    check("arst_cur_layer", cur_layer, 0);
    check("arst_core_start", core_start, 0);
    #1;
    rstn = 1'b1;
    cycle();
    check("arst_rel_clk1", core_rstn, 0);
    cycle();
    check("arst_rel_clk2", core_rstn, 1);
    run_seq(1, t);
    wait_irq(100, "arst_rerun", d);
    check("arst_desc_cleared", insa_log[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
